// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle word-wide RAM port between the
// instruction-fetch requester (IF) and the load/store requester (MEM).
// A winning request is latched in IDLE and held stable on the RAM port
// until ram_ack arrives or the timeout counter expires. In either case
// the requester gets a one-cycle done pulse. A timeout also pulses
// bus_err and returns zero data.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// ties. Without it, MEM always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_re,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_busy,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_data,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_busy,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_req,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                bus_err
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   if_data_reg, if_data_next;
  logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
  logic                err_reg, err_next;
  logic                mem_pend, if_pend, prio_mem, grant_mem, grant_if;
  logic                busy_now, timeout_hit;

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer: 1 = MEM was granted last, 0 = IF was granted last.
  logic                last_mem_reg, last_mem_next;

  // Update the round-robin pointer on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_mem_reg <= 1'b0;
    else        last_mem_reg <= last_mem_next;
  end

  assign prio_mem = ~last_mem_reg;
`else
  assign prio_mem = 1'b1;
`endif

  assign mem_pend    = mem_re | mem_we;
  assign if_pend     = if_re;
  assign grant_mem   = mem_pend & (~if_pend | prio_mem);
  assign grant_if    = if_pend & ~grant_mem;
  assign busy_now    = (state_reg == BUSY_IF) || (state_reg == BUSY_MEM);
  assign timeout_hit = (cnt_reg + 8'd1) == TIMEOUT_L;

  // State and datapath registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      sel_reg      <= sel_next;
      we_reg       <= we_next;
      if_data_reg  <= if_data_next;
      mem_data_reg <= mem_data_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for ack or timeout in BUSY.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    sel_next      = sel_reg;
    we_next       = we_reg;
    if_data_next  = if_data_reg;
    mem_data_next = mem_data_reg;
    err_next      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_mem_next = last_mem_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (grant_mem) begin
          state_next = BUSY_MEM;
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          sel_next   = mem_sel;
          // Asserting re and we together is treated as a write.
          we_next    = mem_we;
`ifdef MEM_ARB_RR_EN
          last_mem_next = 1'b1;
`endif
        end else if (grant_if) begin
          state_next = BUSY_IF;
          addr_next  = if_addr;
          wdata_next = '0;
          sel_next   = '1;
          we_next    = 1'b0;
`ifdef MEM_ARB_RR_EN
          last_mem_next = 1'b0;
`endif
        end
      end
      BUSY_IF, BUSY_MEM: begin
        cnt_next = cnt_reg + 8'd1;
        // An ack on the last allowed cycle still counts as success.
        if (ram_ack || timeout_hit) begin
          cnt_next   = '0;
          err_next   = ~ram_ack;
          state_next = (state_reg == BUSY_IF) ? DONE_IF : DONE_MEM;
          if (state_reg == BUSY_IF) if_data_next  = ram_ack ? ram_rdata : '0;
          else                      mem_data_next = ram_ack ? ram_rdata : '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_req   = busy_now;
  assign ram_we    = we_reg;
  assign ram_sel   = sel_reg;
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign if_busy   = (state_reg != IDLE) && (state_reg != DONE_IF);
  assign mem_busy  = (state_reg != IDLE) && (state_reg != DONE_MEM);
  assign if_done   = (state_reg == DONE_IF);
  assign mem_done  = (state_reg == DONE_MEM);
  assign if_data   = if_data_reg;
  assign mem_rdata = mem_data_reg;
  assign bus_err   = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It applies a table of directed
// transactions, then hand-written tie and reset sequences, then random
// transactions. The random transactions are predicted by a
// transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_re, mem_re, mem_we, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_sel;
  logic        if_busy, if_done, mem_busy, mem_done, ram_req, ram_we, bus_err;
  logic [31:0] if_data, mem_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_sel;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;
  logic        model_last_mem;
  logic [31:0] model_if_data, model_mem_data;

  typedef struct {
    logic        if_re, mem_re, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    int          ack_at;
    logic [31:0] rdata;
    logic        exp_mem, exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic        exp_err;
    int          done_at;
  } vec_t;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_re(if_re), .if_addr(if_addr), .if_busy(if_busy), .if_done(if_done), .if_data(if_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transaction starting in an IDLE cycle (cycle 0).
  task automatic apply(input vec_t v);
    chk("idle_if_busy", if_busy, 0);
    chk("idle_mem_busy", mem_busy, 0);
    chk("idle_ram_req", ram_req, 0);
    if_re = v.if_re; mem_re = v.mem_re; mem_we = v.mem_we;
    if_addr = v.if_addr; mem_addr = v.mem_addr; mem_wdata = v.mem_wdata; mem_sel = v.mem_sel;
    ram_ack = 1'($urandom % 2);
    ram_rdata = $urandom;
    tick();
    for (int c = 1; c < v.done_at; c++) begin
      chk("busy_ram_req", ram_req, 1);
      chk("busy_ram_addr", ram_addr, v.exp_addr);
      chk("busy_ram_we", ram_we, v.exp_we);
      chk("busy_ram_sel", ram_sel, v.exp_sel);
      if (v.exp_mem) chk("busy_ram_wdata", ram_wdata, v.exp_wdata);
      chk("busy_if_busy", if_busy, 1);
      chk("busy_mem_busy", mem_busy, 1);
      chk("busy_if_done", if_done, 0);
      chk("busy_mem_done", mem_done, 0);
      chk("busy_bus_err", bus_err, 0);
      // Scramble requester fields: they must not be re-sampled.
      if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
      ram_ack = (c == v.ack_at);
      ram_rdata = ram_ack ? v.rdata : $urandom;
      tick();
    end
    if (v.exp_mem) model_mem_data = v.exp_data;
    else           model_if_data  = v.exp_data;
    model_last_mem = v.exp_mem;
    chk("done_ram_req", ram_req, 0);
    chk("done_if_done", if_done, !v.exp_mem);
    chk("done_mem_done", mem_done, v.exp_mem);
    chk("done_if_busy", if_busy, v.exp_mem);
    chk("done_mem_busy", mem_busy, !v.exp_mem);
    chk("done_bus_err", bus_err, v.exp_err);
    chk("done_if_data", if_data, model_if_data);
    chk("done_mem_rdata", mem_rdata, model_mem_data);
    $display("txn %0d: grant=%s addr=%h we=%0d sel=%h ack_at=%0d data=%h err=%0d",
             n_txn, v.exp_mem ? "MEM" : "IF", v.exp_addr, v.exp_we, v.exp_sel,
             v.ack_at, v.exp_data, v.exp_err);
    n_txn++;
    if_re = 0; mem_re = 0; mem_we = 0;
    ram_ack = 1'($urandom % 2);
    tick();
    chk("post_if_done", if_done, 0);
    chk("post_mem_done", mem_done, 0);
    chk("post_bus_err", bus_err, 0);
    chk("post_ram_req", ram_req, 0);
    ram_ack = 0;
  endtask

  vec_t tbl[7];
  vec_t tie[3];
  vec_t v;

  initial begin
    // if_re mem_re mem_we if_addr mem_addr mem_wdata sel ack rdata | mem we sel addr wdata data err done
    tbl[0] = '{1, 0, 0, 32'h100, 32'h0,  32'h0,        4'h0, 3, 32'hDEADBEEF, 0, 0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4};
    tbl[1] = '{0, 0, 1, 32'h0,   32'h20, 32'h12345678, 4'h3, 1, 32'hAAAA5555, 1, 1, 4'h3, 32'h20,  32'h12345678, 32'hAAAA5555, 0, 2};
    tbl[2] = '{0, 1, 0, 32'h0,   32'h44, 32'h0BAD0BAD, 4'hC, 2, 32'hCAFEF00D, 1, 0, 4'hC, 32'h44,  32'h0BAD0BAD, 32'hCAFEF00D, 0, 3};
    tbl[3] = '{0, 1, 1, 32'h0,   32'h48, 32'h55AA55AA, 4'h1, 1, 32'h11112222, 1, 1, 4'h1, 32'h48,  32'h55AA55AA, 32'h11112222, 0, 2};
    tbl[4] = '{1, 0, 0, 32'h300, 32'h0,  32'h0,        4'h0, 0, 32'h0,        0, 0, 4'hF, 32'h300, 32'h0,        32'h0,        1, 5};
    tbl[5] = '{0, 1, 0, 32'h0,   32'h60, 32'h0,        4'hF, 4, 32'h87654321, 1, 0, 4'hF, 32'h60,  32'h0,        32'h87654321, 0, 5};
    tbl[6] = '{0, 0, 1, 32'h0,   32'h64, 32'h99999999, 4'h6, 0, 32'h0,        1, 1, 4'h6, 32'h64,  32'h99999999, 32'h0,        1, 5};

`ifdef MEM_ARB_RR_EN
    tie[0] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA0, 1, 0, 4'hF, 32'h500, 32'h0, 32'hA0, 0, 2};
    tie[1] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA1, 0, 0, 4'hF, 32'h400, 32'h0, 32'hA1, 0, 2};
    tie[2] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA2, 1, 0, 4'hF, 32'h500, 32'h0, 32'hA2, 0, 2};
`else
    tie[0] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA0, 1, 0, 4'hF, 32'h500, 32'h0, 32'hA0, 0, 2};
    tie[1] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA1, 1, 0, 4'hF, 32'h500, 32'h0, 32'hA1, 0, 2};
    tie[2] = '{1, 1, 0, 32'h400, 32'h500, 32'h0, 4'hF, 1, 32'hA2, 1, 0, 4'hF, 32'h500, 32'h0, 32'hA2, 0, 2};
`endif

    rst_n = 0; if_re = 0; mem_re = 0; mem_we = 0; ram_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0; ram_rdata = 0;
    model_last_mem = 0; model_if_data = 0; model_mem_data = 0;
    repeat (2) tick();

    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_sel", ram_sel, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_busy", if_busy, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_busy", mem_busy, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) apply(tbl[i]);

    // Reset during cycle 2 of a MEM read: the request drops at once.
    mem_re = 1; mem_addr = 32'h80; mem_sel = 4'hF;
    tick();
    chk("mid_ram_req_c1", ram_req, 1);
    tick();
    rst_n = 0;
    #1;
    chk("mid_rst_ram_req", ram_req, 0);
    chk("mid_rst_mem_busy", mem_busy, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    mem_re = 0; mem_addr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_mem_done", mem_done, 0);
    end
    rst_n = 1;
    model_last_mem = 0; model_if_data = 0; model_mem_data = 0;
    tick();
    v = '{1, 0, 0, 32'h1C0, 32'h0, 32'h0, 4'h0, 2, 32'h0F0F0F0F, 0, 0, 4'hF, 32'h1C0, 32'h0, 32'h0F0F0F0F, 0, 3};
    apply(v);

    // Both requesters asserted for three back-to-back transactions.
    for (int i = 0; i < 3; i++) apply(tie[i]);

    // Random transactions checked against the transaction-level model.
    for (int i = 0; i < 60; i++) begin
      logic prio, acked;
      int kind;
      kind = $urandom_range(0, 2);
      v.if_re = (kind != 1);
      if (kind != 0) begin
        case ($urandom_range(0, 2))
          0:       begin v.mem_re = 1; v.mem_we = 0; end
          1:       begin v.mem_re = 0; v.mem_we = 1; end
          default: begin v.mem_re = 1; v.mem_we = 1; end
        endcase
      end else begin
        v.mem_re = 0; v.mem_we = 0;
      end
      v.if_addr = $urandom; v.mem_addr = $urandom; v.mem_wdata = $urandom;
      v.mem_sel = 4'($urandom); v.rdata = $urandom;
      v.ack_at = $urandom_range(0, 6);
`ifdef MEM_ARB_RR_EN
      prio = !model_last_mem;
`else
      prio = 1;
`endif
      v.exp_mem   = (v.mem_re || v.mem_we) && (!v.if_re || prio);
      v.exp_we    = v.exp_mem ? v.mem_we : 1'b0;
      v.exp_sel   = v.exp_mem ? v.mem_sel : 4'hF;
      v.exp_addr  = v.exp_mem ? v.mem_addr : v.if_addr;
      v.exp_wdata = v.mem_wdata;
      acked       = (v.ack_at >= 1) && (v.ack_at <= TO);
      v.exp_data  = acked ? v.rdata : 32'h0;
      v.exp_err   = !acked;
      v.done_at   = acked ? v.ack_at + 1 : TO + 1;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
